// File: rtl/ram40_rr_arbiter_if.sv
// Requester-side bundle of the block-RAM arbiter: packed per-requester
// request fields, one-hot grant/response strobes and shared read data.
interface ram40_rr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_we;
  logic [NUM_REQ*ADDR_BITS-1:0] req_addr;
  logic [NUM_REQ*DATA_BITS-1:0] req_wdata;
  logic [NUM_REQ*DATA_BITS-1:0] req_mask;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0]           rsp_valid;
  logic [DATA_BITS-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ram40_rr_arbiter.sv
// Round-robin arbiter sharing one SB_RAM40_4K between NUM_REQ requesters;
// zero-fills the RAM after every reset before the first grant.
module ram40_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  ram40_rr_arbiter_if.slave    bus,
  output logic                 init_done,
  output logic [ADDR_BITS-1:0] ram_waddr,
  output logic [ADDR_BITS-1:0] ram_raddr,
  output logic [DATA_BITS-1:0] ram_wdata,
  output logic [DATA_BITS-1:0] ram_mask,
  output logic                 ram_we,
  output logic                 ram_re,
  input  logic [DATA_BITS-1:0] ram_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] LAST_ADDR = (ADDR_BITS+1)'(DEPTH - 1);
  localparam logic [PTR_W-1:0]   LAST_REQ  = PTR_W'(NUM_REQ - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t               state;
  logic [ADDR_BITS:0]   init_cnt;
  logic [PTR_W-1:0]     rr_ptr;
  logic                 rd_pend;
  logic [PTR_W-1:0]     rd_id;
  logic [ADDR_BITS-1:0] last_waddr;
  logic [ADDR_BITS-1:0] last_raddr;
  logic [DATA_BITS-1:0] last_wdata;
  logic [DATA_BITS-1:0] last_mask;

  logic                 grant_any;
  logic [PTR_W-1:0]     grant_id;
  int                   idx;
  logic                 transfer;
  logic                 g_we;
  logic [ADDR_BITS-1:0] g_addr;
  logic [DATA_BITS-1:0] g_wdata;
  logic [DATA_BITS-1:0] g_mask;

  // Scan from rr_ptr upward with explicit wrap so non-power-of-2 counts work.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = PTR_W'(idx);
      end
    end
  end

  assign transfer = (state == RUN) && grant_any;
  assign g_we     = bus.req_we[grant_id];
  assign g_addr   = bus.req_addr[int'(grant_id)*ADDR_BITS +: ADDR_BITS];
  assign g_wdata  = bus.req_wdata[int'(grant_id)*DATA_BITS +: DATA_BITS];
  assign g_mask   = bus.req_mask[int'(grant_id)*DATA_BITS +: DATA_BITS];

  always_comb begin
    bus.req_ready = '0;
    if (transfer) bus.req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (rd_pend) bus.rsp_valid[rd_id] = 1'b1;
  end

  assign bus.rsp_rdata = ram_rdata;

  // Address/data buses fall back to the held values on idle cycles.
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = last_waddr;
    ram_raddr = last_raddr;
    ram_wdata = last_wdata;
    ram_mask  = last_mask;
    if (state == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt[ADDR_BITS-1:0];
      ram_wdata = '0;
      ram_mask  = '0;
    end else if (transfer) begin
      if (g_we) begin
        ram_we    = 1'b1;
        ram_waddr = g_addr;
        ram_wdata = g_wdata;
        ram_mask  = g_mask;
      end else begin
        ram_re    = 1'b1;
        ram_raddr = g_addr;
      end
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= INIT;
      init_cnt   <= '0;
      rr_ptr     <= '0;
      rd_pend    <= 1'b0;
      rd_id      <= '0;
      init_done  <= 1'b0;
      last_waddr <= '0;
      last_raddr <= '0;
      last_wdata <= '0;
      last_mask  <= '0;
    end else begin
      last_waddr <= ram_waddr;
      last_raddr <= ram_raddr;
      last_wdata <= ram_wdata;
      last_mask  <= ram_mask;
      rd_pend    <= transfer && !g_we;
      rd_id      <= grant_id;
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          if (transfer) rr_ptr <= (grant_id == LAST_REQ) ? '0 : grant_id + 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram40_rr_arbiter.sv
// Directed bench for ram40_rr_arbiter: behavioural SB_RAM40_4K, reference
// memory and a read-response scoreboard keyed by grant cycle.
module tb_ram40_rr_arbiter;
  localparam int NR = 4;
  localparam int AB = 8;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          init_done;
  logic [AB-1:0] ram_waddr, ram_raddr;
  logic [DB-1:0] ram_wdata, ram_mask, ram_rdata;
  logic          ram_we, ram_re;

  always #5 clk = ~clk;

  ram40_rr_arbiter_if #(.NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  ram40_rr_arbiter #(.NUM_REQ(NR), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .init_done (init_done),
    .ram_waddr (ram_waddr),
    .ram_raddr (ram_raddr),
    .ram_wdata (ram_wdata),
    .ram_mask  (ram_mask),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata)
  );

  // Block RAM model; contents are scrambled while reset is held so only the
  // arbiter's zero-fill can make unwritten reads return zero.
  logic [DB-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= DB'(i * 37 + 1);
    end else begin
      if (ram_we) ram_mem[ram_waddr] <= (ram_mem[ram_waddr] & ram_mask) | (ram_wdata & ~ram_mask);
      if (ram_re) ram_rdata <= ram_mem[ram_raddr];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int            id;
    logic [DB-1:0] data;
    int            cyc;
  } rd_t;
  rd_t sb[$];
  rd_t mon_e;

  // Expected response is due exactly one cycle after its grant cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
      mon_e = sb.pop_front();
      check("rsp_valid", 32'(bus.rsp_valid), 32'(1 << mon_e.id));
      check("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_e.data));
    end else begin
      check("rsp_idle", 32'(bus.rsp_valid), 32'd0);
    end
  end

  logic [NR-1:0] tb_we;
  logic [AB-1:0] tb_addr  [NR];
  logic [DB-1:0] tb_wdata [NR];
  logic [DB-1:0] tb_mask  [NR];
  logic [DB-1:0] exp_mem  [256];
  logic [AB-1:0] last_w, last_r;

  task automatic set_req(input int i, input logic we, input logic [AB-1:0] addr,
                         input logic [DB-1:0] wdata, input logic [DB-1:0] mask);
    tb_we[i]    = we;
    tb_addr[i]  = addr;
    tb_wdata[i] = wdata;
    tb_mask[i]  = mask;
    bus.req_we[i]              = we;
    bus.req_addr[i*AB +: AB]   = addr;
    bus.req_wdata[i*DB +: DB]  = wdata;
    bus.req_mask[i*DB +: DB]   = mask;
  endtask

  // One arbitration cycle: g is the requester the bench expects to win, -1 for none.
  task automatic drive(input logic [NR-1:0] valid, input int g);
    logic [NR-1:0] exp_rdy;
    bus.req_valid = valid;
    #1;
    exp_rdy = (g < 0) ? '0 : NR'(1 << g);
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (g < 0) begin
      check("idle_we", 32'(ram_we), 32'd0);
      check("idle_re", 32'(ram_re), 32'd0);
      check("idle_waddr_hold", 32'(ram_waddr), 32'(last_w));
      check("idle_raddr_hold", 32'(ram_raddr), 32'(last_r));
    end else if (tb_we[g]) begin
      check("wr_we", 32'(ram_we), 32'd1);
      check("wr_re", 32'(ram_re), 32'd0);
      check("wr_waddr", 32'(ram_waddr), 32'(tb_addr[g]));
      check("wr_wdata", 32'(ram_wdata), 32'(tb_wdata[g]));
      check("wr_mask", 32'(ram_mask), 32'(tb_mask[g]));
      exp_mem[tb_addr[g]] = (exp_mem[tb_addr[g]] & tb_mask[g]) | (tb_wdata[g] & ~tb_mask[g]);
      last_w = tb_addr[g];
    end else begin
      check("rd_re", 32'(ram_re), 32'd1);
      check("rd_we", 32'(ram_we), 32'd0);
      check("rd_raddr", 32'(ram_raddr), 32'(tb_addr[g]));
      sb.push_back('{id: g, data: exp_mem[tb_addr[g]], cyc: cyc});
      last_r = tb_addr[g];
    end
    @(posedge clk);
    #1;
  endtask

  // Release reset and follow the zero-fill sweep address by address.
  task automatic init_sweep();
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    last_w = 8'hFF;
    last_r = 8'h00;
    resetn = 1'b1;
    for (int k = 0; k < 256; k++) begin
      #1;
      check("init_we", 32'(ram_we), 32'd1);
      check("init_waddr", 32'(ram_waddr), 32'(k));
      check("init_no_ready", 32'(bus.req_ready), 32'd0);
      check("init_done_low", 32'(init_done), 32'd0);
      if (k == 0) begin
        check("init_wdata", 32'(ram_wdata), 32'd0);
        check("init_mask", 32'(ram_mask), 32'd0);
        check("init_re", 32'(ram_re), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    check("init_done_rise", 32'(init_done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn        = 1'b0;
    bus.req_valid = '0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AB'(i), '0, '0);
    bus.req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp", 32'(bus.rsp_valid), 32'd0);

    init_sweep();
    bus.req_valid = '0;

    // Single write then read of the same address, then an unwritten address.
    set_req(2, 1'b1, 8'h10, 16'hA5A5, 16'h0000); drive(4'b0100, 2);
    set_req(2, 1'b0, 8'h10, '0, '0);             drive(4'b0100, 2);
    set_req(2, 1'b0, 8'h33, '0, '0);             drive(4'b0100, 2);
    drive(4'b0000, -1);

    // Masked write: upper byte protected.
    set_req(1, 1'b1, 8'h05, 16'hFFFF, 16'hFF00); drive(4'b0010, 1);
    set_req(1, 1'b0, 8'h05, '0, '0);             drive(4'b0010, 1);
    drive(4'b0000, -1);

    // Back-to-back reads from two requesters.
    set_req(0, 1'b1, 8'h01, 16'h1111, '0); drive(4'b0001, 0);
    set_req(3, 1'b1, 8'h02, 16'h2222, '0); drive(4'b1000, 3);
    set_req(0, 1'b0, 8'h01, '0, '0);
    set_req(3, 1'b0, 8'h02, '0, '0);
    drive(4'b1001, 0);
    drive(4'b1000, 3);
    drive(4'b0000, -1);

    // Round-robin with all requesters held, then with requester 1 dropped.
    set_req(0, 1'b0, 8'h10, '0, '0);
    set_req(1, 1'b0, 8'h33, '0, '0);
    set_req(2, 1'b0, 8'h05, '0, '0);
    set_req(3, 1'b0, 8'h01, '0, '0);
    for (int n = 0; n < 8; n++) drive(4'b1111, n % 4);
    drive(4'b1101, 0);
    drive(4'b1101, 2);
    drive(4'b1101, 3);
    drive(4'b1101, 0);
    drive(4'b0000, -1);

    // Reset in the cycle after a read grant drops the response.
    set_req(2, 1'b0, 8'h10, '0, '0);
    drive(4'b0100, 2);
    resetn = 1'b0;
    sb.delete();
    #1;
    check("midrst_rsp", 32'(bus.rsp_valid), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_ready", 32'(bus.req_ready), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("midrst_rsp_hold", 32'(bus.rsp_valid), 32'd0);
    end
    bus.req_valid = 4'b1111;
    init_sweep();

    // Pointer must be back at requester 0 after the second fill.
    drive(4'b1111, 0);
    drive(4'b0000, -1);
    drive(4'b0000, -1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram40_rr_arbiter.md
Name: ram40_rr_arbiter

Overview:
- Shares one SB_RAM40_4K (256x16, READ_MODE=0/WRITE_MODE=0) between NUM_REQ requesters, each with a valid/ready request port.
- Grants one access per cycle, round-robin, and drives the RAM's write and read ports.
- Zero-fills the RAM after every reset before the first grant.
- Sits between fabric clients and a single block RAM: RAM WCLK and RCLK both tie to clk.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_BITS, 8, RAM address width; depth = 2**ADDR_BITS.
- DATA_BITS, 16, RAM data width.

Ports:
- clk  input  1  clock; also drives RAM WCLK/RCLK.
- resetn  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  request pending, one bit per requester.
- req_we  input  NUM_REQ  1 = write, 0 = read.
- req_addr  input  NUM_REQ*ADDR_BITS  packed addresses; requester i uses slice i.
- req_wdata  input  NUM_REQ*DATA_BITS  packed write data.
- req_mask  input  NUM_REQ*DATA_BITS  packed per-bit write mask; 1 = bit NOT written (iCE40 polarity).
- req_ready  output  NUM_REQ  one-hot grant, combinational.
- rsp_valid  output  NUM_REQ  one-hot read-data-valid strobe.
- rsp_rdata  output  DATA_BITS  read data, shared by all requesters.
- init_done  output  1  high once zero-fill completes.
- ram_waddr  output  ADDR_BITS  RAM write address.
- ram_raddr  output  ADDR_BITS  RAM read address.
- ram_wdata  output  DATA_BITS  RAM write data.
- ram_mask  output  DATA_BITS  RAM write mask.
- ram_we  output  1  RAM write enable.
- ram_re  output  1  RAM read enable.
- ram_rdata  input  DATA_BITS  RAM read data.

Behaviour:
- FSM states: INIT, RUN. resetn low forces INIT with:
  - init_cnt=0, rr_ptr=0, rsp_valid=0, rd_pend=0, init_done=0, req_ready=0.
- INIT:
  - ram_we=1, ram_waddr=init_cnt, ram_wdata=0, ram_mask=0, ram_re=0.
  - init_cnt increments each cycle.
  - After address 2**ADDR_BITS-1 is written, go to RUN and set init_done=1 on the next edge.
  - Total INIT length is 256 cycles for the default parameters.
  - All req_ready stay 0 during INIT.
- RUN, grant selection:
  - Scan requesters rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - The first one with req_valid=1 gets req_ready[g]=1; all other req_ready bits are 0.
  - A transfer happens when req_valid[g] & req_ready[g].
  - No grant when no req_valid is set.
- RUN, RAM drive on a transfer by requester g:
  - Write (req_we[g]=1): ram_we=1, ram_waddr=addr[g], ram_wdata=wdata[g], ram_mask=mask[g], ram_re=0.
  - Read (req_we[g]=0): ram_re=1, ram_raddr=addr[g], ram_we=0.
  - Idle cycles: ram_we=0, ram_re=0; address and data outputs hold their last values.
- Pointer update: rr_ptr <= (g+1) mod NUM_REQ on every transfer; it holds when there is no grant.
- Read latency:
  - A read granted in cycle T gives rsp_valid[g]=1 for exactly cycle T+1.
  - rsp_rdata = ram_rdata (direct pass-through) in that cycle.
  - rsp_valid is registered from the grant (rd_pend, rd_id).
  - Back-to-back reads give one rsp_valid per cycle.
- Ordering and fairness:
  - Only one access per cycle, so there are no same-cycle read/write collisions.
  - A read granted the cycle after a write to the same address returns the new data.
  - Starvation bound: a requester holding req_valid is granted within NUM_REQ transfers.
  - Requesters hold addr/data/we stable while valid and not ready. The arbiter samples only on the grant cycle.
- Reset mid-operation:
  - In-flight read response is dropped (rsp_valid forced 0).
  - INIT restarts from address 0.
  - rr_ptr returns to 0.
- Widths: init_cnt is ADDR_BITS+1 bits. rr_ptr is clog2(NUM_REQ) bits, with explicit wrap for non-power-of-2 NUM_REQ.

Test Plan:
- Reset release:
  - init_done rises after exactly 256 cycles.
  - ram_we=1 with waddr 0..255 in sequence.
  - No req_ready during INIT, even with all req_valid=4'b1111.
- Single read/write:
  - Req 2 writes 16'hA5A5 to addr 8'h10 with mask 0.
  - Then reads 8'h10: rsp_valid=4'b0100 one cycle after the grant, rsp_rdata=16'hA5A5.
  - A read of unwritten addr 8'h33 returns 16'h0000.
- Round-robin:
  - All four requesters hold valid continuously.
  - Grants follow 0,1,2,3,0,1; rr_ptr wraps 3->0.
  - Drop req 1: sequence becomes 0,2,3,0.
- Mask:
  - Write 16'hFFFF with mask 16'hFF00 to addr 5, previously 0.
  - Readback is 16'h00FF.
- Back-to-back reads:
  - Req 0 and req 3 read addrs 1 and 2, holding 16'h1111 and 16'h2222, in consecutive cycles.
  - rsp_valid goes 0001 then 1000, with rsp_rdata 1111 then 2222.
- Reset mid-read:
  - Assert resetn=0 in the cycle after a read grant.
  - rsp_valid stays 0, init_done drops, INIT restarts at address 0.
